// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with occupancy count, almost-full/empty flags and sticky errors
module sync_fifo_param #(
  parameter int DATA_W = 128,
  parameter int DEPTH = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_wren,
  input  logic [DATA_W-1:0] i_wrdata,
  input  logic              i_rden,
  input  logic              i_clr_err,
  output logic [DATA_W-1:0] o_rddata,
  output logic              o_rdvalid,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_alm_full,
  output logic              o_alm_empty,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_overflow,
  output logic              o_underflow
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_CNT = CNT_W'(AE_THRESH);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic              w_wr_ok, w_rd_ok;
  logic [CNT_W-1:0]  w_count_nxt;
  assign w_wr_ok = i_wren & ~o_full;
  assign w_rd_ok = i_rden & ~o_empty;
  assign w_count_nxt = o_count + CNT_W'(w_wr_ok) - CNT_W'(w_rd_ok);
  always_ff @(posedge clk)
    if (w_wr_ok) r_mem[r_wr_ptr] <= i_wrdata;
  // flags decode the next count so they line up with o_count after each edge
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      o_rddata    <= '0;
      o_rdvalid   <= 1'b0;
      o_count     <= '0;
      o_full      <= 1'b0;
      o_empty     <= 1'b1;
      o_alm_full  <= 1'b0;
      o_alm_empty <= 1'b1;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      r_wr_ptr    <= r_wr_ptr + PTR_W'(w_wr_ok);
      r_rd_ptr    <= r_rd_ptr + PTR_W'(w_rd_ok);
      o_rdvalid   <= w_rd_ok;
      if (w_rd_ok) o_rddata <= r_mem[r_rd_ptr];
      o_count     <= w_count_nxt;
      o_full      <= w_count_nxt == FULL_CNT;
      o_empty     <= w_count_nxt == '0;
      o_alm_full  <= w_count_nxt >= AF_CNT;
      o_alm_empty <= w_count_nxt <= AE_CNT;
      o_overflow  <= (i_wren & o_full) | (o_overflow & ~i_clr_err);
      o_underflow <= (i_rden & o_empty) | (o_underflow & ~i_clr_err);
    end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: two FIFO configurations driven by shared stimulus, each scored against a queue model
module tb_sync_fifo_param;
  logic clk = 0, rstn = 1, wren = 0, rden = 0, clr = 0;
  logic [127:0] wrdata = '0;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int DW = g == 0 ? 128 : 32;
    localparam int DP = g == 0 ? 16 : 64;
    localparam int AF = g == 0 ? 14 : 60;
    localparam int AE = g == 0 ? 2 : 4;
    localparam int CW = $clog2(DP) + 1;
    logic [DW-1:0] rddata;
    logic [CW-1:0] cnt;
    logic rdvalid, full, empty, afull, aempty, ovf, udf;
    logic [DW-1:0] q[$];
    logic [DW-1:0] sb[$];
    logic [DW-1:0] m_last = '0;
    logic m_rdv = 0, m_ovf = 0, m_udf = 0, was_full, was_empty;

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .AF_THRESH(AF), .AE_THRESH(AE)) u_dut (
      .clk(clk), .rstn(rstn), .i_wren(wren), .i_wrdata(wrdata[DW-1:0]), .i_rden(rden),
      .i_clr_err(clr), .o_rddata(rddata), .o_rdvalid(rdvalid), .o_full(full), .o_empty(empty),
      .o_alm_full(afull), .o_alm_empty(aempty), .o_count(cnt), .o_overflow(ovf), .o_underflow(udf));

    always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        q.delete();
        sb.delete();
        m_rdv = 0;
        m_ovf = 0;
        m_udf = 0;
        m_last = '0;
      end else begin
        was_full = q.size() == DP;
        was_empty = q.size() == 0;
        m_rdv = rden && !was_empty;
        if (m_rdv) sb.push_back(q.pop_front());
        if (wren && !was_full) q.push_back(wrdata[DW-1:0]);
        m_ovf = (wren && was_full) || (m_ovf && !clr);
        m_udf = (rden && was_empty) || (m_udf && !clr);
      end
    end

    always @(negedge clk) begin
      chk($sformatf("g%0d.rdvalid", g), 128'(rdvalid), 128'(m_rdv));
      if (rdvalid || sb.size() != 0) begin
        chk($sformatf("g%0d.sb_depth", g), 128'(sb.size()), 128'(rdvalid));
        if (rdvalid && sb.size() != 0) m_last = sb.pop_front();
      end
      chk($sformatf("g%0d.rddata", g), 128'(rddata), 128'(m_last));
      chk($sformatf("g%0d.count", g), 128'(cnt), 128'(q.size()));
      chk($sformatf("g%0d.full", g), 128'(full), 128'(q.size() == DP));
      chk($sformatf("g%0d.empty", g), 128'(empty), 128'(q.size() == 0));
      chk($sformatf("g%0d.alm_full", g), 128'(afull), 128'(q.size() >= AF));
      chk($sformatf("g%0d.alm_empty", g), 128'(aempty), 128'(q.size() <= AE));
      chk($sformatf("g%0d.overflow", g), 128'(ovf), 128'(m_ovf));
      chk($sformatf("g%0d.underflow", g), 128'(udf), 128'(m_udf));
    end
  end

  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic cyc(input bit w, input bit r, input logic [127:0] d, input bit c);
    wren = w;
    rden = r;
    wrdata = d;
    clr = c;
    @(negedge clk);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2 rstn = 0;
    #1;
    chk("rst.g0.count", 128'(gi[0].cnt), 128'(0));
    chk("rst.g0.empty", 128'(gi[0].empty), 128'(1));
    chk("rst.g0.alm_empty", 128'(gi[0].aempty), 128'(1));
    chk("rst.g0.full", 128'(gi[0].full), 128'(0));
    chk("rst.g0.rddata", 128'(gi[0].rddata), 128'(0));
    chk("rst.g0.overflow", 128'(gi[0].ovf), 128'(0));
    chk("rst.g1.count", 128'(gi[1].cnt), 128'(0));
    chk("rst.g1.empty", 128'(gi[1].empty), 128'(1));
    chk("rst.g1.rdvalid", 128'(gi[1].rdvalid), 128'(0));
    @(negedge clk);
    @(negedge clk);
    rstn = 1;
  endtask

  initial begin
    int bias;
    #1 rstn = 0;
    repeat (3) @(negedge clk);
    rstn = 1;
    for (int i = 0; i < 17; i++) cyc(1, 0, 128'(i), 0);
    for (int i = 0; i < 18; i++) cyc(0, 1, '0, 0);
    cyc(0, 0, '0, 1);
    for (int i = 0; i < 8; i++) cyc(1, 0, rnd(), 0);
    for (int i = 0; i < 40; i++) cyc(1, 1, rnd(), 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, '0, 0);
    for (int i = 0; i < 16; i++) cyc(1, 0, rnd(), 0);
    cyc(1, 1, rnd(), 0);
    cyc(0, 0, '0, 1);
    for (int i = 0; i < 20; i++) cyc(0, 1, '0, 0);
    cyc(1, 1, rnd(), 0);
    cyc(0, 0, '0, 1);
    for (int i = 0; i < 70; i++) cyc(1, 0, rnd(), i == 35);
    for (int i = 0; i < 70; i++) cyc(0, 1, '0, i == 35);
    mid_reset();
    for (int s = 0; s < 12; s++) begin
      bias = $urandom_range(10, 90);
      for (int i = 0; i < 150; i++)
        cyc($urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias, rnd(), $urandom_range(0, 99) < 5);
      if (s == 6) mid_reset();
    end
    cyc(0, 0, '0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
